// File: rtl/mixed_block_c_hdr_arb_pkg.sv
// Shared types for the mixedBlockC header arbiter: requester id, beat index,
// header word, the seeSt tag and the arbiter state encoding.
package mixed_block_c_hdr_arb_pkg;

  // Requester id (up to 4 requesters).
  typedef logic [1:0]  c_size_t;
  // Beat index within a burst (1..7).
  typedef logic [2:0]  c_size_plus_t;
  // Header word carried on the cHeaderSt channel.
  typedef logic [12:0] c_header_t;

  // Tag attached to every output beat: who sent it and which beat of the burst.
  typedef struct packed {
    c_size_t      variablec;   // owner id
    c_size_plus_t variablec2;  // beat index, 1-based
  } see_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  localparam int CSIZE_PLUS      = 3;
  localparam int C_ARB_MAX_BURST = 4;

  // Increment a requester id, wrapping at n.
  function automatic c_size_t wrap_inc(input c_size_t v, input int n);
    if (int'(v) >= n - 1) return '0;
    return c_size_t'(v + 2'd1);
  endfunction

endpackage

// File: rtl/mixed_block_c_hdr_arb_c_rr_pick.sv
// Rotate-priority picker: returns the first set bit of elig_i scanning
// start_i, start_i+1, ... modulo NUM_REQ.
module c_rr_pick
  import mixed_block_c_hdr_arb_pkg::*;
#(
  parameter int NUM_REQ = CSIZE_PLUS
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  c_size_t            start_i,
  output logic               found_o,
  output c_size_t            idx_o
);

  // Walk the candidates in rotated order and keep the first eligible one.
  always_comb begin
    int j;
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(start_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found_o && elig_i[j]) begin
        found_o = 1'b1;
        idx_o   = c_size_t'(j);
      end
    end
  end

endmodule

// File: rtl/mixed_block_c_hdr_arb.sv
// Round-robin burst arbiter for the mixedBlockC header channel. One requester
// owns the channel for up to MAX_BURST back-to-back beats; the winning header
// is registered together with a seeSt tag {owner id, beat index}.
module mixed_block_c_hdr_arb
  import mixed_block_c_hdr_arb_pkg::*;
#(
  parameter int NUM_REQ   = CSIZE_PLUS,
  parameter int MAX_BURST = C_ARB_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_mask,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*13-1:0] req_hdr,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [12:0]           out_hdr,
  output logic [4:0]            out_see,
  output logic                  busy
);

  arb_state_t   state_q, state_d;
  c_size_t      owner_q, owner_d;
  c_size_t      rr_ptr_q, rr_ptr_d;
  c_size_plus_t beat_q, beat_d;
  logic         out_valid_q, out_valid_d;
  c_header_t    out_hdr_q, out_hdr_d;
  see_t         out_see_q, out_see_d;

  logic               load;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] owner_onehot;
  logic               cont;
  c_size_t            pick_start;
  logic               pick_found;
  c_size_t            pick_idx;
  logic               grant_found;
  c_size_t            grant_idx;
  c_size_plus_t       grant_beat;
  c_header_t          grant_hdr;

  // Output register may take a new beat when empty or being drained this cycle.
  assign load = !out_valid_q || out_ready;
  assign elig = req_valid & ~req_mask;

  // Burst continuation and the start point for a fresh arbitration.
  always_comb begin
    owner_onehot = NUM_REQ'(1) << owner_q;
    cont         = (state_q == ARB_BURST) && |(elig & owner_onehot) &&
                   (beat_q < c_size_plus_t'(MAX_BURST));
    // On release the old owner moves to lowest priority.
    pick_start   = (state_q == ARB_BURST) ? wrap_inc(owner_q, NUM_REQ) : rr_ptr_q;
  end

  c_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .elig_i  (elig),
    .start_i (pick_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Resolve this cycle's winner, its beat index and its header.
  always_comb begin
    grant_found = load && (cont || pick_found);
    grant_idx   = cont ? owner_q : pick_idx;
    grant_beat  = cont ? c_size_plus_t'(beat_q + 3'd1) : c_size_plus_t'(1);
    grant_hdr   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == c_size_t'(i)) grant_hdr = req_hdr[13*i +: 13];
    end
  end

  // One-hot accept towards the winner; held low while in reset.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rst_n && grant_found && (grant_idx == c_size_t'(i));
    end
  end

  // Next-state logic: burst bookkeeping and round-robin pointer update.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    beat_d   = beat_q;
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      if ((state_q == ARB_BURST) && !cont) rr_ptr_d = pick_start;
      if (grant_found) begin
        state_d = ARB_BURST;
        owner_d = grant_idx;
        beat_d  = grant_beat;
      end else begin
        state_d = ARB_IDLE;
      end
    end
  end

  // Output register next values; held while the consumer stalls.
  always_comb begin
    out_valid_d = out_valid_q;
    out_hdr_d   = out_hdr_q;
    out_see_d   = out_see_q;
    if (load) begin
      out_valid_d = grant_found;
      if (grant_found) begin
        out_hdr_d = grant_hdr;
        out_see_d = '{variablec: grant_idx, variablec2: grant_beat};
      end
    end
  end

  // Arbiter state register.
  // NOTE: all state is cleared by the asynchronous reset so a mid-burst reset restarts cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      beat_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q  <= state_d;
      owner_q  <= owner_d;
      beat_q   <= beat_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Output beat register; an in-flight beat is discarded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_hdr_q   <= '0;
      out_see_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_hdr_q   <= out_hdr_d;
      out_see_q   <= out_see_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_hdr   = out_hdr_q;
  assign out_see   = out_see_q;
  assign busy      = (state_q == ARB_BURST);

endmodule

// File: tb/tb_mixed_block_c_hdr_arb.sv
// Self-checking bench for mixed_block_c_hdr_arb: directed scenarios followed
// by a randomized phase, all compared against a cycle-level reference model.
module tb_mixed_block_c_hdr_arb;

  localparam int N  = 3;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_mask;
  logic [N-1:0]     req_valid;
  logic [N*13-1:0]  req_hdr;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic             out_ready;
  logic [12:0]      out_hdr;
  logic [4:0]       out_see;
  logic             busy;

  mixed_block_c_hdr_arb #(
    .NUM_REQ   (N),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_mask  (req_mask),
    .req_valid (req_valid),
    .req_hdr   (req_hdr),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hdr   (out_hdr),
    .out_see   (out_see),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: who owns the channel, how many beats so far, where the
  // next fresh search starts, and what the output register should hold.
  bit          m_burst;
  int          m_owner;
  int          m_beat;
  int          m_ptr;
  bit          m_valid;
  logic [12:0] m_hdr;
  logic [4:0]  m_see;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int start, input logic [N-1:0] el);
    for (int k = 0; k < N; k++) begin
      if (el[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] see_of(input int id, input int beat);
    return 32'((id << 3) | beat);
  endfunction

  task automatic randomize_hdr();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    req_hdr = r[N*13-1:0];
  endtask

  task automatic model_reset();
    m_burst = 1'b0;
    m_owner = 0;
    m_beat  = 0;
    m_ptr   = 0;
    m_valid = 1'b0;
    m_hdr   = '0;
    m_see   = '0;
  endtask

  // Reset asserted asynchronously at the current time, held for two edges,
  // released away from the clock edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_hdr",   32'(out_hdr),   32'd0);
    check("rst_out_see",   32'(out_see),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // One clock: check the accept vector against the model, advance the model
  // on the edge, then check the registered outputs.
  task automatic step();
    logic        load;
    logic [N-1:0] el;
    logic [N-1:0] exp_rdy;
    logic [12:0] hdr_s;
    int          win;
    int          nb;
    bit          releasing;
    #1;
    load      = !m_valid || out_ready;
    el        = req_valid & ~req_mask;
    win       = -1;
    nb        = 0;
    releasing = 1'b0;
    hdr_s     = '0;
    if (load) begin
      if (m_burst && el[m_owner] && m_beat < MB) begin
        win = m_owner;
        nb  = m_beat + 1;
      end else begin
        releasing = m_burst;
        win = pick(m_burst ? (m_owner + 1) % N : m_ptr, el);
        nb  = 1;
      end
    end
    exp_rdy = '0;
    if (win >= 0) begin
      exp_rdy[win] = 1'b1;
      hdr_s = req_hdr[13*win +: 13];
    end
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (load) begin
      if (releasing) m_ptr = (m_owner + 1) % N;
      m_burst = (win >= 0);
      m_valid = (win >= 0);
      if (win >= 0) begin
        m_owner = win;
        m_beat  = nb;
        m_hdr   = hdr_s;
        m_see   = 5'(see_of(win, nb));
      end
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("busy",      32'(busy),      32'(m_burst));
    if (m_valid) begin
      check("out_hdr", 32'(out_hdr), 32'(m_hdr));
      check("out_see", 32'(out_see), 32'(m_see));
    end
  endtask

  initial begin
    logic [4:0] saved_see;
    logic [12:0] saved_hdr;

    req_mask  = '0;
    req_valid = '1;
    out_ready = 1'b1;
    randomize_hdr();
    model_reset();

    // Reset with every requester valid: nothing may be accepted.
    apply_reset();

    // Fairness from reset: 4 beats each, starting at req0.
    for (int k = 0; k < 14; k++) begin
      randomize_hdr();
      step();
      check("rr_see", 32'(out_see), see_of((k / 4) % 3, (k % 4) + 1));
    end

    // Backpressure mid-burst: output must hold, nothing accepted.
    saved_see = out_see;
    saved_hdr = out_hdr;
    out_ready = 1'b0;
    repeat (5) begin
      randomize_hdr();
      step();
    end
    check("stall_see", 32'(out_see), 32'(saved_see));
    check("stall_hdr", 32'(out_hdr), 32'(saved_hdr));
    out_ready = 1'b1;
    randomize_hdr();
    step();
    check("resume_see", 32'(out_see), see_of(0, 3));
    step();

    // Early release: req1 drops after beat 2, req2 takes over with no bubble.
    apply_reset();
    req_valid = 3'b110;
    step();
    randomize_hdr();
    step();
    check("early_see_b2", 32'(out_see), see_of(1, 2));
    req_valid = 3'b100;
    randomize_hdr();
    step();
    check("early_valid", 32'(out_valid), 32'd1);
    check("early_see", 32'(out_see), see_of(2, 1));

    // Masked requesters: only req1 eligible, re-wins after MAX_BURST.
    apply_reset();
    req_mask  = 3'b101;
    req_valid = 3'b111;
    for (int k = 0; k < 5; k++) begin
      randomize_hdr();
      step();
      check("mask_see", 32'(out_see), see_of(1, (k < 4) ? k + 1 : 1));
    end
    req_mask = '0;

    // Asynchronous reset at beat 3, then arbitration restarts at req0.
    apply_reset();
    repeat (3) begin
      randomize_hdr();
      step();
    end
    check("pre_rst_see", 32'(out_see), see_of(0, 3));
    #3;
    apply_reset();
    step();
    check("post_rst_see", 32'(out_see), see_of(0, 1));

    // Randomized traffic, backpressure and mask changes.
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) req_mask = ($urandom_range(2) == 0) ? N'($urandom_range(7)) : '0;
      req_valid = N'($urandom_range(7));
      out_ready = ($urandom_range(3) != 0);
      randomize_hdr();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
